// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS symbol source: mode encodings and default
// LFSR polynomial/seed for the 22-bit configuration.
package prbs_pkg;

   typedef enum logic [1:0] {
      MODE_PRBS   = 2'b00,
      MODE_CONST  = 2'b01,
      MODE_ALT    = 2'b10,
      MODE_FREEZE = 2'b11
   } mode_e;

   localparam int          DEF_N    = 22;
   localparam logic [21:0] DEF_TAPS = 22'h300000;  // x^22 + x^21 + 1
   localparam logic [21:0] DEF_SEED = 22'h3FFFFF;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with seed load; a zero seed is replaced by
// SEED so the register can never enter the all-zero lock-up state.
module lfsr_core #(
   parameter int           N    = 22,
   parameter logic [N-1:0] TAPS = {2'b11, {(N-2){1'b0}}},
   parameter logic [N-1:0] SEED = {N{1'b1}}
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         advance,
   input  logic         load,
   input  logic [N-1:0] seed_in,
   output logic [N-1:0] q,
   output logic [N-1:0] q_next
);

   assign q_next = {q[N-2:0], ^(q & TAPS)};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset)
         q <= SEED;
      else if (load)
         q <= (seed_in == '0) ? SEED : seed_in;
      else if (advance)
         q <= q_next;
   end

endmodule

// File: rtl/prbs_sym_gen.sv
// PRBS I/Q symbol source: LFSR plus sequence counter, wrap pulse and a
// mode-selected symbol register updated once per sample enable.
module prbs_sym_gen
   import prbs_pkg::*;
#(
   parameter int                N        = DEF_N,
   parameter logic [N-1:0]      TAPS     = N'(DEF_TAPS),
   parameter logic [N-1:0]      SEED     = {N{1'b1}},
   parameter int                SYM_BITS = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sam_clk_ena,
   input  logic                load_data,
   input  logic [N-1:0]        seed_in,
   input  logic [1:0]          mode,
   output logic [SYM_BITS-1:0] I_sym,
   output logic [SYM_BITS-1:0] Q_sym,
   output logic                sym_valid,
   output logic                wrap,
   output logic [N-1:0]        LFSR_Counter,
   output logic [N-1:0]        q
);

   mode_e        mode_sel;
   logic         advance;
   logic         toggle;
   logic [N-1:0] q_next;

   assign mode_sel = mode_e'(mode);
   assign advance  = sam_clk_ena && (mode_sel != MODE_FREEZE);

   lfsr_core #(
      .N    (N),
      .TAPS (TAPS),
      .SEED (SEED)
   ) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .advance (advance),
      .load    (load_data),
      .seed_in (seed_in),
      .q       (q),
      .q_next  (q_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         LFSR_Counter <= N'(1);
         I_sym        <= '0;
         Q_sym        <= '0;
         sym_valid    <= 1'b0;
         wrap         <= 1'b0;
         toggle       <= 1'b0;
      end else begin
         sym_valid <= 1'b0;
         wrap      <= 1'b0;
         if (load_data) begin
            LFSR_Counter <= N'(1);
            toggle       <= 1'b0;
         end else if (advance) begin
            sym_valid <= 1'b1;
            if (q_next == SEED) begin
               LFSR_Counter <= N'(1);
               wrap         <= 1'b1;
            end else begin
               LFSR_Counter <= LFSR_Counter + N'(1);
            end
            // Symbols come from the pre-shift state, one cycle after the enable.
            case (mode_sel)
               MODE_PRBS: begin
                  I_sym <= q[SYM_BITS-1:0];
                  Q_sym <= q[2*SYM_BITS-1:SYM_BITS];
               end
               MODE_CONST: begin
                  I_sym <= '1;
                  Q_sym <= '1;
               end
               MODE_ALT: begin
                  I_sym  <= toggle ? '0 : '1;
                  Q_sym  <= toggle ? '0 : '1;
                  toggle <= ~toggle;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prbs_sym_gen.sv
// Self-checking bench: a 4-bit and a default 22-bit instance driven by
// directed scenarios and random stimulus against a behavioural model.
module tb_prbs_sym_gen;

   typedef struct {
      logic [21:0] q;
      logic [21:0] cnt;
      logic [1:0]  i;
      logic [1:0]  qs;
      logic        v;
      logic        w;
      logic        tog;
   } mstate_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 4-bit instance stimulus/outputs
   logic        r4 = 1'b0, l4 = 1'b0, e4 = 1'b0;
   logic [3:0]  s4 = '0;
   logic [1:0]  m4 = 2'b00;
   logic [0:0]  i4, qq4;
   logic        v4, w4;
   logic [3:0]  c4, st4q;

   // 22-bit instance stimulus/outputs
   logic        r22 = 1'b0, l22 = 1'b0, e22 = 1'b0;
   logic [21:0] s22 = '0;
   logic [1:0]  m22 = 2'b00;
   logic [1:0]  i22, qq22;
   logic        v22, w22;
   logic [21:0] c22, st22q;

   int total = 0;
   int bad   = 0;
   mstate_t m_4, m_22;

   prbs_sym_gen #(.N(4), .TAPS(4'b1100), .SEED(4'hF), .SYM_BITS(1)) dut4 (
      .clk(clk), .reset(r4), .sam_clk_ena(e4), .load_data(l4), .seed_in(s4),
      .mode(m4), .I_sym(i4), .Q_sym(qq4), .sym_valid(v4), .wrap(w4),
      .LFSR_Counter(c4), .q(st4q)
   );

   prbs_sym_gen dut22 (
      .clk(clk), .reset(r22), .sam_clk_ena(e22), .load_data(l22), .seed_in(s22),
      .mode(m22), .I_sym(i22), .Q_sym(qq22), .sym_valid(v22), .wrap(w22),
      .LFSR_Counter(c22), .q(st22q)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: next state written as arithmetic on integers.
   function automatic mstate_t mstep(mstate_t s, int n, logic [21:0] taps, logic [21:0] seed,
                                     int sb, logic rst, logic ld, logic [21:0] sd,
                                     logic ena, logic [1:0] md);
      mstate_t     r    = s;
      logic [21:0] mask = 22'((23'd1 << n) - 23'd1);
      logic [1:0]  ones = 2'((3'd1 << sb) - 3'd1);
      logic [21:0] nq;
      r.v = 1'b0;
      r.w = 1'b0;
      if (rst) begin
         r.q = seed; r.cnt = 22'd1; r.i = '0; r.qs = '0; r.tog = 1'b0;
      end else if (ld) begin
         r.q   = ((sd & mask) == '0) ? seed : (sd & mask);
         r.cnt = 22'd1;
         r.tog = 1'b0;
      end else if (ena && md != 2'b11) begin
         nq  = ((s.q << 1) | 22'(^(s.q & taps))) & mask;
         r.v = 1'b1;
         case (md)
            2'b00: begin
               r.i  = 2'(s.q) & ones;
               r.qs = 2'(s.q >> sb) & ones;
            end
            2'b01: begin r.i = ones; r.qs = ones; end
            default: begin
               r.i   = s.tog ? 2'b00 : ones;
               r.qs  = r.i;
               r.tog = ~s.tog;
            end
         endcase
         r.q = nq;
         if (nq == seed) begin r.cnt = 22'd1; r.w = 1'b1; end
         else r.cnt = (s.cnt + 22'd1) & mask;
      end
      return r;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
      m_4  = mstep(m_4, 4, 22'hC, 22'hF, 1, r4, l4, 22'(s4), e4, m4);
      m_22 = mstep(m_22, 22, 22'h300000, 22'h3FFFFF, 2, r22, l22, s22, e22, m22);
      check("q4",   32'(st4q), 32'(m_4.q));
      check("cnt4", 32'(c4),   32'(m_4.cnt));
      check("i4",   32'(i4),   32'(m_4.i));
      check("qs4",  32'(qq4),  32'(m_4.qs));
      check("v4",   32'(v4),   32'(m_4.v));
      check("w4",   32'(w4),   32'(m_4.w));
      check("q22",  32'(st22q), 32'(m_22.q));
      check("cnt22",32'(c22),   32'(m_22.cnt));
      check("i22",  32'(i22),   32'(m_22.i));
      check("qs22", 32'(qq22),  32'(m_22.qs));
      check("v22",  32'(v22),   32'(m_22.v));
      check("w22",  32'(w22),   32'(m_22.w));
   endtask

   initial begin
      logic [3:0] seq4 [15] = '{4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3,
                                4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};

      // Reset both instances
      r4 = 1'b1; r22 = 1'b1;
      cycle();
      check("rst4_q", 32'(st4q), 32'hF);
      check("rst22_q", 32'(st22q), 32'h3FFFFF);
      check("rst22_cnt", 32'(c22), 32'd1);
      r4 = 1'b0; r22 = 1'b0;

      // Full period of the 4-bit sequence against the known table
      e4 = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         cycle();
         check("seq4", 32'(st4q), 32'(seq4[k-1]));
         check("wrap_at_15", 32'(w4), 32'(k == 15));
         if (k == 1) check("first_iq", {i4, qq4}, 32'b11);
         if (k == 2) check("second_iq", {i4, qq4}, 32'b01);
         if (k == 15) check("cnt_at_wrap", 32'(c4), 32'd1);
      end

      // Sparse enables: one every four cycles
      for (int k = 0; k < 16; k++) begin
         e4 = (k % 4 == 0);
         cycle();
      end

      // Zero-seed load with coincident enable, then explicit seed 9
      e4 = 1'b1; l4 = 1'b1; s4 = 4'h0;
      cycle();
      check("ld0_q", 32'(st4q), 32'hF);
      check("ld0_cnt", 32'(c4), 32'd1);
      check("ld0_valid", 32'(v4), 32'd0);
      s4 = 4'h9;
      cycle();
      check("ld9_q", 32'(st4q), 32'h9);
      l4 = 1'b0;
      cycle();
      check("adv_after_ld9", 32'(st4q), 32'h3);
      e4 = 1'b0;

      // 22-bit: constant then alternating pattern
      e22 = 1'b1; m22 = 2'b01;
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("const_iq", {i22, qq22}, 32'hF);
      end
      m22 = 2'b10;
      for (int k = 0; k < 6; k++) begin
         cycle();
         check("alt_iq", {i22, qq22}, (k % 2 == 0) ? 32'hF : 32'h0);
      end

      // Freeze with toggling enable, then resume PRBS
      m22 = 2'b11;
      for (int k = 0; k < 10; k++) begin
         e22 = k[0];
         cycle();
         check("freeze_valid", 32'(v22), 32'd0);
      end
      m22 = 2'b00; e22 = 1'b1;
      for (int k = 0; k < 4; k++) cycle();

      // Mid-run reset once the counter reaches 1000
      r22 = 1'b1; e22 = 1'b0;
      cycle();
      r22 = 1'b0; e22 = 1'b1;
      for (int k = 0; k < 999; k++) cycle();
      check("cnt_1000", 32'(c22), 32'd1000);
      r22 = 1'b1;
      cycle();
      check("mid_rst_q", 32'(st22q), 32'h3FFFFF);
      check("mid_rst_cnt", 32'(c22), 32'd1);
      check("mid_rst_iq", {i22, qq22}, 32'h0);
      check("mid_rst_vw", {v22, w22}, 32'h0);
      r22 = 1'b0;

      // Random stimulus on both instances
      for (int k = 0; k < 4000; k++) begin
         r4  = ($urandom_range(0, 199) == 0);
         r22 = ($urandom_range(0, 199) == 0);
         l4  = ($urandom_range(0, 19) == 0);
         l22 = ($urandom_range(0, 19) == 0);
         s4  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
         s22 = ($urandom_range(0, 3) == 0) ? 22'h0 : 22'($urandom);
         e4  = $urandom_range(0, 1) == 1;
         e22 = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 15) == 0) m4  = 2'($urandom);
         if ($urandom_range(0, 15) == 0) m22 = 2'($urandom);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
